// File: rtl/ondra_tone_gen.sv
// Multi-channel square-wave tone generator with a registered volume mix.
// Optional macro ONDRA_TONE_PRESET_EN adds the snd input, which drives channel 0 from fixed preset dividers.
module ondra_tone_gen #(
  parameter  int CHANNELS  = 4,
  parameter  int VOL_WIDTH = 4,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW        = CW + 2,
  localparam int OW        = VOL_WIDTH + $clog2(CHANNELS + 1)
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce,
  input  logic                wr,
  input  logic [AW-1:0]       addr,
  input  logic [7:0]          din,
`ifdef ONDRA_TONE_PRESET_EN
  input  logic [2:0]          snd,
`endif
  output logic [CHANNELS-1:0] tone,
  output logic [OW-1:0]       AUDIO
);

  logic [7:0]           stage_q [CHANNELS];
  logic [7:0]           stage_d [CHANNELS];
  logic [15:0]          div_q   [CHANNELS];
  logic [15:0]          div_d   [CHANNELS];
  logic [15:0]          cnt_q   [CHANNELS];
  logic [15:0]          cnt_d   [CHANNELS];
  logic [VOL_WIDTH-1:0] vol_q   [CHANNELS];
  logic [VOL_WIDTH-1:0] vol_d   [CHANNELS];
  logic [CHANNELS-1:0]  en_q, en_d, tone_d;
  logic [OW-1:0]        audio_d;

  logic [15:0]          eff_div [CHANNELS];
  logic [VOL_WIDTH-1:0] eff_vol [CHANNELS];
  logic [CHANNELS-1:0]  eff_en, locked, reload;
  logic [CHANNELS-1:0]  wr_lo, wr_hi, wr_ctl;

  logic [CW-1:0] ch_sel;
  logic [1:0]    reg_sel;
  assign ch_sel  = addr[AW-1:2];
  assign reg_sel = addr[1:0];

  function automatic logic [15:0] minus_one(input logic [15:0] d);
    return (d == 16'd0) ? 16'd0 : d - 16'd1;
  endfunction

`ifdef ONDRA_TONE_PRESET_EN
  logic [2:0] snd_q;

  function automatic logic [15:0] preset_div(input logic [2:0] s);
    case (s)
      3'd1:    return 16'd10417;
      3'd2:    return 16'd6601;
      3'd3:    return 16'd4837;
      3'd4:    return 16'd2928;
      3'd5:    return 16'd2653;
      3'd6:    return 16'd2477;
      3'd7:    return 16'd2282;
      default: return 16'd0;
    endcase
  endfunction
`endif

  // Effective channel settings: registers, unless a preset owns channel 0.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      eff_en[i]  = en_q[i];
      eff_div[i] = div_q[i];
      eff_vol[i] = vol_q[i];
      locked[i]  = 1'b0;
      reload[i]  = 1'b0;
    end
`ifdef ONDRA_TONE_PRESET_EN
    if (snd != 3'd0) begin
      locked[0]  = 1'b1;
      eff_en[0]  = 1'b1;
      eff_div[0] = preset_div(snd);
      eff_vol[0] = '1;
    end
    reload[0] = (snd != snd_q);
`endif
  end

  // Out-of-range channel indices never match, so those writes fall away.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wr_lo[i]  = wr && (int'(ch_sel) == i) && (reg_sel == 2'd0);
      wr_hi[i]  = wr && (int'(ch_sel) == i) && (reg_sel == 2'd1);
      wr_ctl[i] = wr && (int'(ch_sel) == i) && (reg_sel == 2'd2);
    end
  end

  // NOTE: every always_comb output gets a default before any branch; this keeps
  // the block purely combinational and prevents latch inference.
  always_comb begin
    tone_d  = tone;
    audio_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      stage_d[i] = stage_q[i];
      div_d[i]   = div_q[i];
      en_d[i]    = en_q[i];
      vol_d[i]   = vol_q[i];
      cnt_d[i]   = cnt_q[i];

      if (wr_lo[i]) stage_d[i] = din;
      if (wr_hi[i]) div_d[i]   = {din, stage_q[i]};
      if (wr_ctl[i]) begin
        en_d[i]  = din[0];
        vol_d[i] = din[VOL_WIDTH:1];
      end

      // Priority: preset change, enable edge, divider commit, idle, count.
      if (reload[i]) begin
        cnt_d[i]  = eff_en[i] ? minus_one(eff_div[i]) : 16'd0;
        tone_d[i] = 1'b0;
      end else if (wr_ctl[i] && din[0] && !en_q[i] && !locked[i]) begin
        cnt_d[i]  = minus_one(div_q[i]);
        tone_d[i] = 1'b0;
      end else if (wr_hi[i] && en_q[i] && !locked[i]) begin
        cnt_d[i] = minus_one({din, stage_q[i]});
      end else if (!eff_en[i] || (eff_div[i] == 16'd0)) begin
        cnt_d[i]  = 16'd0;
        tone_d[i] = 1'b0;
      end else if (ce) begin
        if (cnt_q[i] == 16'd0) begin
          cnt_d[i]  = minus_one(eff_div[i]);
          tone_d[i] = ~tone[i];
        end else begin
          cnt_d[i] = cnt_q[i] - 16'd1;
        end
      end

      if (tone[i]) audio_d = audio_d + OW'(eff_vol[i]);
    end
  end

  // NOTE: the per-channel register arrays are reset explicitly because
  // a reset must leave every channel silent and unprogrammed.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        stage_q[i] <= '0;
        div_q[i]   <= '0;
        cnt_q[i]   <= '0;
        vol_q[i]   <= '0;
      end
      en_q  <= '0;
      tone  <= '0;
      AUDIO <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        stage_q[i] <= stage_d[i];
        div_q[i]   <= div_d[i];
        cnt_q[i]   <= cnt_d[i];
        vol_q[i]   <= vol_d[i];
      end
      en_q  <= en_d;
      tone  <= tone_d;
      AUDIO <= audio_d;
    end
  end

`ifdef ONDRA_TONE_PRESET_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) snd_q <= 3'd0;
    else       snd_q <= snd;
  end
`endif

endmodule
